// File: rtl/alu_serdes_pkg.sv
// alu_serdes_pkg
// Shared types for the byte-serial arithmetic unit.
//   state_t : controller states (LOAD_A, LOAD_B, READY, CALC, OUT)
//   op_t    : operation encoding as presented on the op pins
//   idx_bits: width of an index able to address n items (never below 1)
package alu_serdes_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    READY,
    CALC,
    OUT
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_MUL = 2'b11
  } op_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_serdes_if.sv
// alu_serdes_if
// Pin-level bundle between the project mux and alu_serdes.
//   in_byte/in_valid : operand byte stream, little-endian
//   op/start         : operation select and launch
//   out_byte/out_valid/out_ready : result byte stream with handshake
//   busy/ovf         : status
// master = the driver of operands and consumer of results; slave = alu_serdes.
interface alu_serdes_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic [1:0] op;
  logic       start;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       busy;
  logic       ovf;

  modport master (
    output in_byte, in_valid, op, start, out_ready,
    input  out_byte, out_valid, busy, ovf
  );

  modport slave (
    input  in_byte, in_valid, op, start, out_ready,
    output out_byte, out_valid, busy, ovf
  );
endinterface

// File: rtl/alu_serdes_cla.sv
// alu_serdes_cla
// Combinational W-bit adder in generate/propagate form.
//   x_i, y_i : addends
//   cin_i    : carry in
//   sum_o    : x_i + y_i + cin_i, truncated to W bits
// Callers widen their operands by one bit so sum_o[W-1] is the carry out.
module alu_serdes_cla #(
  parameter int W = 17
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;

  assign c[0] = cin_i;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign g[gi]     = x_i[gi] & y_i[gi];
      assign p[gi]     = x_i[gi] ^ y_i[gi];
      assign sum_o[gi] = p[gi] ^ c[gi];
    end
    for (gi = 1; gi < W; gi++) begin : g_carry
      assign c[gi] = g[gi-1] | (p[gi-1] & c[gi-1]);
    end
  endgenerate

endmodule

// File: rtl/alu_serdes.sv
// alu_serdes
// Byte-serial arithmetic unit: loads two WIDTH-bit operands a byte at a time,
// runs ADD / SUB / ACC / MUL and streams the WIDTH-bit result back a byte at a
// time with a valid/ready handshake.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears all state
//   bus : alu_serdes_if.slave (operand stream, op/start, result stream, busy, ovf)
module alu_serdes
  import alu_serdes_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_serdes_if.slave bus
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BW     = idx_bits(NBYTES);
  localparam int CW     = idx_bits(WIDTH);

  state_t             state_q;
  state_t             state_d;
  op_t                op_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   res_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               ovf_q;

  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic               add_cin;
  logic [WIDTH:0]     add_s;

  logic [BW-1:0]      byte_idx;
  logic               last_byte;
  logic               last_mul;
  logic [7:0]         res_bytes [NBYTES];

  // One counter serves as byte index while loading/streaming and as the
  // iteration count during MUL; it is always zero on entry to each phase.
  assign byte_idx  = cnt_q[BW-1:0];
  assign last_byte = (cnt_q == CW'(NBYTES - 1));
  assign last_mul  = (cnt_q == CW'(WIDTH - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_res_byte
      assign res_bytes[gi] = res_q[8*gi +: 8];
    end
  endgenerate

  // Shared adder: operand selection per operation. For MUL the upper product
  // half is the running partial sum and the multiplicand is added only when
  // the current multiplier bit (product LSB) is set.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (op_q)
      OP_ADD: begin
        add_x = {1'b0, a_q};
        add_y = {1'b0, b_q};
      end
      OP_SUB: begin
        add_x   = {1'b0, a_q};
        add_y   = {1'b0, ~b_q};
        add_cin = 1'b1;
      end
      OP_ACC: begin
        add_x = {1'b0, acc_q};
        add_y = {1'b0, a_q};
      end
      OP_MUL: begin
        add_x = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        add_y = prod_q[0] ? {1'b0, a_q} : '0;
      end
      default: ;
    endcase
  end

  alu_serdes_cla #(
    .W(WIDTH + 1)
  ) u_cla (
    .x_i  (add_x),
    .y_i  (add_y),
    .cin_i(add_cin),
    .sum_o(add_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A: if (bus.in_valid && last_byte) state_d = LOAD_B;
      LOAD_B: if (bus.in_valid && last_byte) state_d = READY;
      READY:  if (bus.start) state_d = CALC;
      CALC:   if (op_q != OP_MUL || last_mul) state_d = OUT;
      OUT:    if (bus.out_ready && last_byte) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Outputs
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_byte  = 8'h00;
    bus.busy      = 1'b0;
    bus.ovf       = ovf_q;
    case (state_q)
      CALC: bus.busy = 1'b1;
      OUT: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_byte  = res_bytes[byte_idx];
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_ADD;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      prod_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (bus.in_valid) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (byte_idx == BW'(i)) a_q[8*i +: 8] <= bus.in_byte;
            end
            cnt_q <= last_byte ? '0 : cnt_q + 1'b1;
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (byte_idx == BW'(i)) b_q[8*i +: 8] <= bus.in_byte;
            end
            cnt_q <= last_byte ? '0 : cnt_q + 1'b1;
          end
        end
        READY: begin
          if (bus.start) begin
            op_q   <= op_t'(bus.op);
            // Multiplier sits in the low half and is shifted out LSB first.
            prod_q <= {{WIDTH{1'b0}}, b_q};
          end
        end
        CALC: begin
          if (op_q == OP_MUL) begin
            prod_q <= {add_s, prod_q[WIDTH-1:1]};
            if (last_mul) begin
              cnt_q <= '0;
              res_q <= {add_s[0], prod_q[WIDTH-1:1]};
              ovf_q <= |add_s[WIDTH:1];
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            res_q <= add_s[WIDTH-1:0];
            // For SUB the carry out is the inverted borrow.
            ovf_q <= (op_q == OP_SUB) ? ~add_s[WIDTH] : add_s[WIDTH];
            if (op_q == OP_ACC) acc_q <= add_s[WIDTH-1:0];
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            if (last_byte) begin
              cnt_q <= '0;
              a_q   <= '0;
              b_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serdes.sv
// tb_alu_serdes
// Directed vectors for alu_serdes (WIDTH=16). Stimulus pushes expected result
// bytes into a scoreboard queue; a monitor pops and compares on every output
// handshake.
module tb_alu_serdes;
  import alu_serdes_pkg::*;

  localparam int WIDTH = 16;
  localparam int NB    = WIDTH / 8;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  always #5 clk = ~clk;

  alu_serdes_if bus();

  alu_serdes #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted output byte against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got 0x%02h expected none", bus.out_byte);
      end else begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d: out_byte=0x%02h exp=0x%02h ovf=%0b exp_ovf=%0b",
                 txn, bus.out_byte, e.data, bus.ovf, e.ovf);
        check("out_byte", 32'(bus.out_byte), 32'(e.data));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
  endtask

  // Operand a, one idle gap, then operand b.
  task automatic load(input logic [15:0] a, input logic [15:0] b);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    tick();
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  task automatic push_result(input logic [15:0] z, input logic ov);
    for (int i = 0; i < NB; i++) begin
      sb_q.push_back('{data: 8'(z >> (8 * i)), ovf: ov});
    end
  endtask

  // Pulse start, then count cycles until the first out_valid.
  task automatic start_op(input logic [1:0] op, output int lat);
    bus.op    = op;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_rise", 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (bus.busy && n < 64) begin
      tick();
      n++;
    end
    check("busy_fall", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] z, input logic ov, input int exp_lat);
    int lat;
    load(a, b);
    push_result(z, ov);
    start_op(op, lat);
    check("latency", 32'(lat), 32'(exp_lat));
    wait_idle();
    check("ovf_hold", 32'(bus.ovf), 32'(ov));
  endtask

  initial begin
    int lat;
    rst           = 1'b1;
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_byte", 32'(bus.out_byte), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Basic operations
    run_op(2'b00, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 2);
    run_op(2'b01, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 2);
    run_op(2'b10, 16'h8000, 16'h0000, 16'h8000, 1'b0, 2);
    run_op(2'b10, 16'h8000, 16'h0000, 16'h0000, 1'b1, 2);
    run_op(2'b11, 16'h0100, 16'h0100, 16'h0000, 1'b1, 17);

    // Reset in the fifth MUL CALC cycle
    load(16'h1234, 16'h0567);
    bus.op    = 2'b11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_byte", 32'(bus.out_byte), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    tick();
    run_op(2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2);

    run_op(2'b11, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 17);

    // Backpressure with stray in_valid during OUT and on the final handshake
    bus.out_ready = 1'b0;
    load(16'h00AB, 16'h1100);
    push_result(16'h11AB, 1'b0);
    start_op(2'b00, lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_byte", 32'(bus.out_byte), 32'hAB);
      bus.in_valid = (i == 1);
      bus.in_byte  = 8'h55;
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_byte   = 8'h77;
    tick();
    tick();
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    wait_idle();
    run_op(2'b00, 16'h0102, 16'h0304, 16'h0406, 1'b0, 2);

    // start after only 3 of 4 operand bytes must be ignored
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h04);
    bus.op    = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("early_busy", 32'(bus.busy), 32'd0);
    check("early_valid", 32'(bus.out_valid), 32'd0);
    send_byte(8'h00);
    push_result(16'h0007, 1'b0);
    start_op(2'b00, lat);
    check("early_latency", 32'(lat), 32'd2);
    wait_idle();

    repeat (2) tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
